// File: rtl/inv_round_10_pkg.sv
// inv_round_10_pkg: shared AES decryption constants, inverse S-box and InvShiftRows byte mapping
package inv_round_10_pkg;
  localparam int AES_BLOCK = 128;
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
  function automatic logic [3:0] isr_src(input logic [3:0] i);
    return {i[3:2] - i[1:0], i[1:0]};
  endfunction
endpackage

// File: rtl/inv_round_10_inv_sub_bytes.sv
// inv_sub_bytes: combinational AES InvSubBytes over a 128-bit state
module inv_sub_bytes
  import inv_round_10_pkg::*;
(
  input  logic [AES_BLOCK-1:0] IN,
  output logic [AES_BLOCK-1:0] OUT
);
  for (genvar g = 0; g < 16; g++) begin : g_sbox
    assign OUT[8*g +: 8] = INV_SBOX[IN[8*g +: 8]];
  end
endmodule

// File: rtl/inv_round_10.sv
// inv_round_10: two-stage pipelined AES-128 inverse final round (AddRoundKey, InvShiftRows, InvSubBytes)
module inv_round_10
  import inv_round_10_pkg::*;
#(
  parameter int BLOCK_LENGTH = AES_BLOCK
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BLOCK_LENGTH-1:0] IN,
  input  logic [BLOCK_LENGTH-1:0] KEY,
  input  logic                    key_load,
  input  logic                    in_valid,
  input  logic                    enable,
  output logic [BLOCK_LENGTH-1:0] OUT,
  output logic                    out_valid
);
  logic [BLOCK_LENGTH-1:0] rk_q, rk_d, s1_data_q, s1_data_d, out_q, out_d;
  logic [BLOCK_LENGTH-1:0] ek, ark, isr, isb;
  logic                    s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
  assign ek  = key_load ? KEY : rk_q;
  assign ark = IN ^ ek;
  always_comb begin
    isr = '0;
    for (int i = 0; i < 16; i++)
      isr[127-8*i -: 8] = ark[127-8*int'(isr_src(4'(i))) -: 8];
  end
  inv_sub_bytes u_isb (.IN(s1_data_q), .OUT(isb));
  always_comb begin
    rk_d        = enable && key_load ? KEY : rk_q;
    s1_data_d   = enable ? isr : s1_data_q;
    s1_valid_d  = enable ? in_valid : s1_valid_q;
    out_d       = enable ? isb : out_q;
    out_valid_d = enable ? s1_valid_q : out_valid_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rk_q        <= '0;
      s1_data_q   <= '0;
      s1_valid_q  <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rk_q        <= rk_d;
      s1_data_q   <= s1_data_d;
      s1_valid_q  <= s1_valid_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign OUT       = out_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_inv_round_10.sv
// tb_inv_round_10: scoreboard bench for inv_round_10 against a GF(2^8)-derived reference model
module tb_inv_round_10;
  logic         clk = 1'b0, rst = 1'b0, key_load = 1'b0, in_valid = 1'b0, enable = 1'b0, out_valid;
  logic [127:0] IN = '0, KEY = '0, OUT;
  typedef struct { logic [127:0] data; int tag; } exp_t;
  exp_t         sb[$];
  logic [7:0]   inv_tab [256];
  logic [127:0] rk_m = '0;
  int           checks = 0, failures = 0, en_edges = 0;
  localparam logic [127:0] C1_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1_IN  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
  localparam logic [127:0] ALL52  = {16{8'h52}};
  inv_round_10 dut (.clk(clk), .rst(rst), .IN(IN), .KEY(KEY), .key_load(key_load),
                    .in_valid(in_valid), .enable(enable), .OUT(OUT), .out_valid(out_valid));
  always #5 clk = ~clk;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction
  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, x);
    if (x == 8'h00) v = 8'h00;
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction
  function automatic logic [127:0] ref_round(input logic [127:0] din, input logic [127:0] k);
    logic [127:0] x, o;
    x = din ^ k;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = inv_tab[x[127-8*(4*((c-r+4)%4)+r) -: 8]];
    return o;
  endfunction
  task automatic step(input logic [127:0] din, input logic [127:0] k, input logic kl, input logic iv,
                      input logic en, input logic fx, input logic [127:0] fv);
    logic [127:0] ek;
    @(negedge clk);
    IN = din; KEY = k; key_load = kl; in_valid = iv; enable = en;
    if (en) begin
      ek = kl ? k : rk_m;
      if (kl) rk_m = k;
      if (iv) sb.push_back('{fx ? fv : ref_round(din, ek), en_edges + 2});
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
  endtask
  task automatic hold_check(input string name, input logic ev, input logic cd, input logic [127:0] ed);
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== ev || (cd && OUT !== ed)) begin
      failures++;
      $display("FAIL %s: out_valid=%b OUT=%h required out_valid=%b OUT=%h", name, out_valid, OUT, ev, ed);
    end
  endtask
  always @(posedge clk) begin
    if (rst && enable) begin
      exp_t e;
      en_edges++;
      #1;
      checks++;
      if (out_valid) begin
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out: edge=%0d OUT=%h required no output", en_edges, OUT);
        end else begin
          e = sb.pop_front();
          if (e.tag != en_edges || OUT !== e.data) begin
            failures++;
            $display("FAIL scoreboard: edge=%0d OUT=%h required edge=%0d OUT=%h", en_edges, OUT, e.tag, e.data);
          end
        end
      end else if (sb.size() > 0 && sb[0].tag <= en_edges) begin
        e = sb.pop_front();
        failures++;
        $display("FAIL missing_out: edge=%0d out_valid=0 required OUT=%h", en_edges, e.data);
      end
    end
  end
  initial begin
    logic [127:0] a, b, k1, k2;
    for (int x = 0; x < 256; x++) inv_tab[fwd_sbox(8'(x))] = 8'(x);
    #1;
    checks++;
    if (out_valid !== 1'b0 || OUT !== '0) begin
      failures++;
      $display("FAIL reset_state: out_valid=%b OUT=%h required 0/0", out_valid, OUT);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    step(C1_IN, C1_KEY, 1'b1, 1'b1, 1'b1, 1'b1, C1_OUT);
    idle(3);
    k1 = {$urandom, $urandom, $urandom, $urandom};
    step(k1, k1, 1'b1, 1'b1, 1'b1, 1'b1, ALL52);
    idle(3);
    for (int i = 0; i < 4; i++) step({$urandom, $urandom, $urandom, $urandom}, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    idle(4);
    step(C1_IN, C1_KEY, 1'b1, 1'b1, 1'b1, 1'b1, C1_OUT);
    for (int i = 0; i < 3; i++) begin
      step({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      hold_check("stall_empty", 1'b0, 1'b0, '0);
    end
    idle(1);
    for (int i = 0; i < 2; i++) begin
      step({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      hold_check("stall_full", 1'b1, 1'b1, C1_OUT);
    end
    step(C1_IN, '0, 1'b0, 1'b1, 1'b1, 1'b1, C1_OUT);
    idle(3);
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    step(a, k1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    step(b, k2, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    step(a, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    idle(3);
    step(a, k1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    step(b, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    step('0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    rk_m = '0;
    checks++;
    if (out_valid !== 1'b0 || OUT !== '0) begin
      failures++;
      $display("FAIL async_reset: out_valid=%b OUT=%h required 0/0", out_valid, OUT);
    end
    hold_check("reset_hold", 1'b0, 1'b1, '0);
    @(negedge clk);
    rst = 1'b1;
    idle(4);
    step(C1_IN, C1_KEY, 1'b1, 1'b1, 1'b1, 1'b1, C1_OUT);
    for (int i = 0; i < 300; i++)
      step({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 1'b0, '0);
    idle(4);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
